id_scoreboard: RTL

- Parametrised hazard unit for the ID stage; replaces the fixed single-cycle load-use check.
- Tracks the remaining result latency of every in-flight destination register: ALU ops, loads, and multi-cycle MUL/DIV.
- Generates stall, IF write-enable and the issue strobe for the instruction in ID.
- Sits beside the Decode/Registers logic; Decode supplies the latency class of each instruction.

---
 rtl/id_pkg.sv | 16 +
 rtl/sb_counter.sv | 31 +++
 rtl/id_scoreboard.sv | 99 +++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared constants for the ID-stage scoreboard: latency classes,
// default maximum latency and the counter-width helper.
package id_pkg;

    localparam int MAX_LAT_DEF = 8;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = MAX_LAT_DEF;

    function automatic int cnt_width(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// One register's remaining-latency counter: load on issue, else count down to 0.
// Ports: clk, rst_n, i_load, i_load_val, o_busy (cnt != 0), o_cnt.
module sb_counter
    import id_pkg::*;
#(
    parameter int CNT_W = cnt_width(MAX_LAT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage hazard unit tracking remaining result latency per register.
// Inputs: ID instruction fields (valid, rs1/rs2/rd, latency class), flush.
// Outputs: stall, if_write, issue, busy_mask.
// Optional ID_SCOREBOARD_PERF_EN adds perf_raw_cnt / perf_waw_cnt.
module id_scoreboard
    import id_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int MAX_LAT  = MAX_LAT_DEF,
    localparam int REG_AW   = $clog2(NUM_REGS),
    localparam int CNT_W    = cnt_width(MAX_LAT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1_addr,
    input  logic [REG_AW-1:0]   id_rs2_addr,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd_addr,
    input  logic                id_rd_we,
    input  logic [CNT_W-1:0]    id_lat,
    input  logic                flush,
    output logic                stall,
    output logic                if_write,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef ID_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]         perf_raw_cnt,
    output logic [31:0]         perf_waw_cnt
`endif
);

    logic [CNT_W-1:0] w_cnt [NUM_REGS];
    logic [CNT_W-1:0] w_lat_c;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_stall;
    logic             w_issue;

    assign w_lat_c = (id_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : id_lat;

    // Checks use the pre-issue counters, so rd == rs waits on the old value.
    assign w_raw1 = id_rs1_used & (id_rs1_addr != '0)
                  & (w_cnt[id_rs1_addr] != '0);
    assign w_raw2 = id_rs2_used & (id_rs2_addr != '0)
                  & (w_cnt[id_rs2_addr] != '0);
    // An older, slower write must not land after this younger one.
    assign w_waw  = id_rd_we & (id_rd_addr != '0)
                  & (w_cnt[id_rd_addr] > w_lat_c);

    assign w_stall = id_valid & ~flush & (w_raw1 | w_raw2 | w_waw);
    assign w_issue = id_valid & ~flush & ~w_stall;

    assign stall    = w_stall;
    assign if_write = ~w_stall;
    assign issue    = w_issue;

    assign w_cnt[0]     = '0;
    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_issue & id_rd_we & (id_rd_addr == REG_AW'(r))),
            .i_load_val(w_lat_c),
            .o_busy    (busy_mask[r]),
            .o_cnt     (w_cnt[r])
        );
    end

`ifdef ID_SCOREBOARD_PERF_EN
    logic [31:0] r_perf_raw;
    logic [31:0] r_perf_waw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_raw <= '0;
            r_perf_waw <= '0;
        end else begin
            if (w_stall & (w_raw1 | w_raw2) & (r_perf_raw != '1)) begin
                r_perf_raw <= r_perf_raw + 32'd1;
            end
            if (w_stall & w_waw & ~w_raw1 & ~w_raw2 & (r_perf_waw != '1)) begin
                r_perf_waw <= r_perf_waw + 32'd1;
            end
        end
    end

    assign perf_raw_cnt = r_perf_raw;
    assign perf_waw_cnt = r_perf_waw;
`endif

endmodule
